vc_queue: RTL
=============

Name: vc_queue

Overview:
- Parametrised successor to the single-channel NoC queue: NUM_VC independent virtual-channel FIFOs, each DEPTH flits of FLIT_W bits.
- Sits at a router input port between link receiver and switch allocator.
- Adds per-VC status, credit return toward the upstream router, registered read data, and sticky overflow/underflow error flags.

Parameters:
- FLIT_W, 32, flit width in bits.
- NUM_VC, 4, number of virtual channels; >=2.
- DEPTH, 4, flits per VC; power of two, >=2.
- AF_LEVEL, DEPTH-1, occupancy at or above which vc_almost_full asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_vc  in  VC_W  target VC of write (VC_W = max(1,$clog2(NUM_VC))).
- wr_data  in  FLIT_W  flit to write.
- rd_en  in  1  read request.
- rd_vc  in  VC_W  VC to pop.
- rd_data  out  FLIT_W  popped flit, registered.
- rd_valid  out  1  rd_data valid this cycle.
- rd_vc_out  out  VC_W  VC that rd_data came from.
- credit_valid  out  1  one-cycle credit-return pulse.
- credit_vc  out  VC_W  VC whose slot was freed.
- vc_empty  out  NUM_VC  per-VC empty.
- vc_full  out  NUM_VC  per-VC full.
- vc_almost_full  out  NUM_VC  per-VC count >= AF_LEVEL.
- ovf_err  out  1  sticky: write to a full VC occurred.
- udf_err  out  1  sticky: read from an empty VC occurred.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous): all heads, tails and counts = 0. vc_empty all 1s; vc_full and vc_almost_full all 0s. rd_valid, credit_valid, ovf_err, udf_err = 0. rd_data, rd_vc_out, credit_vc = 0. Storage contents are not reset.
- Reset mid-operation discards all queued flits; no credits are issued for them.
- Per VC: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count is $clog2(DEPTH+1) bits.
  - empty = (count==0); full = (count==DEPTH).
  - vc_empty, vc_full and vc_almost_full are decoded from registered count (no combinational path from inputs).
- Write:
  - If wr_en and VC not full: store at tail, tail++, count++.
  - If wr_en and VC full: write dropped, ovf_err set next cycle.
- Read, 1-cycle latency:
  - If rd_en and VC not empty at edge N: head flit is registered. At N+1: rd_data = flit, rd_vc_out = rd_vc, rd_valid = 1, credit_valid = 1, credit_vc = rd_vc. Then head++, count--.
  - If rd_en and VC empty: no pop; rd_valid and credit_valid are 0 next cycle; udf_err is set.
  - rd_data holds its last value when rd_valid = 0.
- Simultaneous read and write:
  - Same VC, not empty: both occur; count unchanged. Legal even when full, because the read frees the slot this cycle and no ovf occurs.
  - Same VC, empty: write occurs, read is an underflow; the written flit is not bypassed.
  - Different VCs: fully independent.
- err_clr: clears flags at the next edge. A new error event in the same cycle wins, so the flag stays 1.
- Credit protocol: upstream starts with DEPTH credits per VC. credit_valid is at most one pulse per cycle and is produced only by successful pops.

Decomposition:
- noc_pkg: FLIT_W default, NUM_VC default, VC_W localparam, typedef flit_t, typedef vc_id_t.
- Sub-module vc_fifo_slice: one VC's storage, pointers, count and status; instantiated NUM_VC times via generate.
- vc_queue top: write/read decode, output register stage, credit logic, error flags.

Test Plan (NUM_VC=4, DEPTH=4, FLIT_W=32):
- Reset with rst_n=0 mid-stream -> outputs zero immediately (asynchronous), vc_empty=4'b1111; after release, the first read of VC0 gives udf_err=1 and rd_valid=0.
- Write 0xA0..0xA3 to VC2, then read VC2 four times -> rd_data A0,A1,A2,A3 on consecutive cycles, each one cycle after rd_en; credit_vc=2 with four pulses; vc_full[2] is 1 after the 4th write; vc_almost_full[2] is 1 after the 3rd write.
- Fill VC1, write 0xBAD -> ovf_err=1, VC1 still returns only the original 4 flits; err_clr -> ovf_err=0.
- VC3 full, simultaneous write 0xC4 and read -> rd_data is the oldest flit, count stays 4, no ovf_err; after draining, the last flit read is 0xC4.
- Interleave writes to VC0 (0x10,0x11) and VC1 (0x20,0x21), read VC1 then VC0 -> rd_data 0x20 with rd_vc_out=1, then 0x10 with rd_vc_out=0; per-VC ordering preserved.
- Wrap-around: 10 push/pop pairs on VC0 with data 0..9 -> outputs 0..9 in order, vc_empty[0]=1 at the end.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared defaults and types for the router input-port virtual-channel queue.
// VC_W for any NUM_VC comes from vc_width(); DEF_VC_W applies it to the default.
package noc_pkg;

   localparam int DEF_FLIT_W = 32;
   localparam int DEF_NUM_VC = 4;
   localparam int DEF_DEPTH  = 4;

   // A single VC still needs a one-bit id so port widths never collapse to zero.
   function automatic int vc_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_VC_W = vc_width(DEF_NUM_VC);

   typedef logic [DEF_FLIT_W-1:0] flit_t;
   typedef logic [DEF_VC_W-1:0]   vc_id_t;

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual channel: circular flit storage, head/tail pointers, occupancy count
// and status flags decoded from the registered count.
module vc_fifo_slice
   import noc_pkg::*;
#(
   parameter int FLIT_W   = DEF_FLIT_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [FLIT_W-1:0] wr_data,
   output logic [FLIT_W-1:0] head_data,
   output logic              empty,
   output logic              full,
   output logic              almost_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (pop) begin
            head_reg <= head_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_data   = mem[head_reg];
   assign empty       = (count_reg == '0);
   assign full        = (count_reg == CNT_W'(DEPTH));
   assign almost_full = (count_reg >= CNT_W'(AF_LEVEL));

endmodule

// File: rtl/vc_queue.sv
// Router input-port queue: NUM_VC independent flit FIFOs with registered pop data,
// credit return toward the upstream router and sticky overflow/underflow flags.
module vc_queue
   import noc_pkg::*;
#(
   parameter int FLIT_W   = DEF_FLIT_W,
   parameter int NUM_VC   = DEF_NUM_VC,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   localparam int VC_W    = vc_width(NUM_VC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [VC_W-1:0]   wr_vc,
   input  logic [FLIT_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [VC_W-1:0]   rd_vc,
   output logic [FLIT_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [VC_W-1:0]   rd_vc_out,
   output logic              credit_valid,
   output logic [VC_W-1:0]   credit_vc,
   output logic [NUM_VC-1:0] vc_empty,
   output logic [NUM_VC-1:0] vc_full,
   output logic [NUM_VC-1:0] vc_almost_full,
   output logic              ovf_err,
   output logic              udf_err,
   input  logic              err_clr
);

   logic [NUM_VC-1:0] wr_hit;
   logic [NUM_VC-1:0] rd_hit;
   logic [NUM_VC-1:0] push;
   logic [NUM_VC-1:0] pop;
   logic [FLIT_W-1:0] head_data [NUM_VC];

   logic pop_any;
   logic ovf_ev;
   logic udf_ev;

   // A write into a full VC still lands when the same VC pops this cycle.
   for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign wr_hit[gi] = wr_en && (wr_vc == VC_W'(gi));
      assign rd_hit[gi] = rd_en && (rd_vc == VC_W'(gi));
      assign pop[gi]    = rd_hit[gi] && !vc_empty[gi];
      assign push[gi]   = wr_hit[gi] && (!vc_full[gi] || pop[gi]);

      vc_fifo_slice #(
         .FLIT_W   (FLIT_W),
         .DEPTH    (DEPTH),
         .AF_LEVEL (AF_LEVEL)
      ) u_slice (
         .clk         (clk),
         .rst_n       (rst_n),
         .push        (push[gi]),
         .pop         (pop[gi]),
         .wr_data     (wr_data),
         .head_data   (head_data[gi]),
         .empty       (vc_empty[gi]),
         .full        (vc_full[gi]),
         .almost_full (vc_almost_full[gi])
      );
   end

   assign pop_any = |pop;
   assign ovf_ev  = |(wr_hit & vc_full & ~pop);
   assign udf_ev  = |(rd_hit & vc_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         rd_vc_out    <= '0;
         credit_valid <= 1'b0;
         credit_vc    <= '0;
      end else begin
         rd_valid     <= pop_any;
         credit_valid <= pop_any;
         if (pop_any) begin
            rd_data   <= head_data[rd_vc];
            rd_vc_out <= rd_vc;
            credit_vc <= rd_vc;
         end
      end
   end

   // A fresh error in the clearing cycle keeps its flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else if (err_clr) begin
         ovf_err <= ovf_ev;
         udf_err <= udf_ev;
      end else begin
         ovf_err <= ovf_err | ovf_ev;
         udf_err <= udf_err | udf_ev;
      end
   end

endmodule
